// File: rtl/cleanup_pkg.sv
// Shared definitions for the button/tick cleanup blocks: FSM state encoding and
// synchroniser depth.
package cleanup_pkg;

    localparam logic [1:0] S_LOW  = 2'd0;
    localparam logic [1:0] S_RISE = 2'd1;
    localparam logic [1:0] S_HIGH = 2'd2;
    localparam logic [1:0] S_FALL = 2'd3;

    localparam int unsigned SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        StLow  = S_LOW,
        StRise = S_RISE,
        StHigh = S_HIGH,
        StFall = S_FALL
    } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Flop-chain synchroniser for a single asynchronous level input.
module sync_2ff
    import cleanup_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/button_cleanup.sv
// Push-button debouncer: synchronises btn_raw, samples it on sample_en and accepts a level
// change only after STABLE_SAMPLES agreeing samples; counts aborted transitions.
module button_cleanup
    import cleanup_pkg::*;
#(
    parameter int unsigned STABLE_SAMPLES = 4,
    parameter int unsigned CNT_W          = 3,
    parameter int unsigned BOUNCE_W       = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                btn_raw,
    input  logic                sample_en,
    input  logic                bounce_clr,
    output logic                btn_clean,
    output logic                press_pulse,
    output logic                release_pulse,
    output logic [BOUNCE_W-1:0] bounce_count
);

    localparam logic [CNT_W-1:0]    LastCnt   = CNT_W'(STABLE_SAMPLES - 1);
    localparam logic [BOUNCE_W-1:0] BounceMax = '1;

    logic             btn_s;
    logic             bounce_inc;
    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_raw),
        .q   (btn_s)
    );

    // A sample disagreeing with a pending transition aborts it and counts as a bounce.
    always_comb begin
        bounce_inc = sample_en &&
                     (((state_q == StRise) && !btn_s) || ((state_q == StFall) && btn_s));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StLow;
            cnt_q         <= '0;
            btn_clean     <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
            bounce_count  <= '0;
        end else begin
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;

            if (sample_en) begin
                unique case (state_q)
                    StLow: begin
                        if (btn_s) begin
                            state_q <= StRise;
                            cnt_q   <= CNT_W'(1);
                        end
                    end
                    StRise: begin
                        if (!btn_s) begin
                            state_q <= StLow;
                            cnt_q   <= '0;
                        end else if (cnt_q == LastCnt) begin
                            state_q     <= StHigh;
                            cnt_q       <= '0;
                            btn_clean   <= 1'b1;
                            press_pulse <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    StHigh: begin
                        if (!btn_s) begin
                            state_q <= StFall;
                            cnt_q   <= CNT_W'(1);
                        end
                    end
                    StFall: begin
                        if (btn_s) begin
                            state_q <= StHigh;
                            cnt_q   <= '0;
                        end else if (cnt_q == LastCnt) begin
                            state_q       <= StLow;
                            cnt_q         <= '0;
                            btn_clean     <= 1'b0;
                            release_pulse <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: begin
                        state_q <= StLow;
                        cnt_q   <= '0;
                    end
                endcase
            end

            if (bounce_clr) begin
                bounce_count <= '0;
            end else if (bounce_inc && (bounce_count != BounceMax)) begin
                bounce_count <= bounce_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_button_cleanup.sv
// Self-checking bench for button_cleanup: directed vector table, corner-case sequences and
// randomized stimulus against a run-length reference model.
module tb_button_cleanup;

    localparam int unsigned N  = 4;
    localparam int unsigned BW = 8;
    localparam int         BMAX = (1 << BW) - 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          btn_raw;
    logic          sample_en;
    logic          bounce_clr;
    logic          btn_clean;
    logic          press_pulse;
    logic          release_pulse;
    logic [BW-1:0] bounce_count;

    always #5 clk = ~clk;

    button_cleanup #(
        .STABLE_SAMPLES (N),
        .CNT_W          (3),
        .BOUNCE_W       (BW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .btn_raw       (btn_raw),
        .sample_en     (sample_en),
        .bounce_clr    (bounce_clr),
        .btn_clean     (btn_clean),
        .press_pulse   (press_pulse),
        .release_pulse (release_pulse),
        .bounce_count  (bounce_count)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: the clean level plus the length of the current run of samples
    // that disagree with it; btn_s is btn_raw as it was two edges earlier.
    bit m_clean;
    int m_run;
    int m_bounce;
    bit m_press;
    bit m_release;
    bit raw_q[$];

    int press_seen;
    int release_seen;

    typedef struct {
        bit raw;
        int ticks;
        bit clean;
        int press;
        int rel;
        int bounce;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 40)
                $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_clean   = 1'b0;
        m_run     = 0;
        m_bounce  = 0;
        m_press   = 1'b0;
        m_release = 1'b0;
        raw_q     = '{1'b0, 1'b0};
    endtask

    task automatic model_edge();
        bit s;
        bit inc;
        s = raw_q[0];
        void'(raw_q.pop_front());
        raw_q.push_back(btn_raw);
        m_press   = 1'b0;
        m_release = 1'b0;
        inc       = 1'b0;
        if (sample_en) begin
            if (s != m_clean) begin
                m_run++;
                if (m_run == N) begin
                    m_clean = s;
                    m_run   = 0;
                    if (s) m_press = 1'b1;
                    else   m_release = 1'b1;
                end
            end else begin
                if (m_run > 0) inc = 1'b1;
                m_run = 0;
            end
        end
        if (bounce_clr) m_bounce = 0;
        else if (inc && m_bounce < BMAX) m_bounce++;
    endtask

    task automatic cycle();
        @(posedge clk);
        if (rst) model_reset();
        else model_edge();
        #1;
        check("clean", btn_clean, m_clean);
        check("press", press_pulse, m_press);
        check("release", release_pulse, m_release);
        check("bounce", bounce_count, m_bounce);
        press_seen   += int'(press_pulse);
        release_seen += int'(release_pulse);
    endtask

    task automatic tick(input bit raw, input bit clr);
        btn_raw    = raw;
        sample_en  = 1'b0;
        bounce_clr = 1'b0;
        repeat (9) cycle();
        sample_en  = 1'b1;
        bounce_clr = clr;
        cycle();
        sample_en  = 1'b0;
        bounce_clr = 1'b0;
    endtask

    // Asserts rst between clock edges and checks outputs clear without waiting for an edge.
    task automatic do_reset();
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check("rst_async_clean", btn_clean, 0);
        check("rst_async_press", press_pulse, 0);
        check("rst_async_release", release_pulse, 0);
        check("rst_async_bounce", bounce_count, 0);
        repeat (2) cycle();
        #2;
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        btn_raw    = 1'b0;
        sample_en  = 1'b0;
        bounce_clr = 1'b0;
        model_reset();
        press_seen   = 0;
        release_seen = 0;
        repeat (3) cycle();
        rst = 1'b0;
        check("reset_clean", btn_clean, 0);
        check("reset_bounce", bounce_count, 0);

        vecs[0] = '{1'b1, 4, 1'b1, 1, 0, 0};
        vecs[1] = '{1'b0, 4, 1'b0, 0, 1, 0};
        vecs[2] = '{1'b1, 2, 1'b0, 0, 0, 0};
        vecs[3] = '{1'b0, 1, 1'b0, 0, 0, 1};
        vecs[4] = '{1'b1, 3, 1'b0, 0, 0, 1};
        vecs[5] = '{1'b0, 1, 1'b0, 0, 0, 2};
        vecs[6] = '{1'b1, 5, 1'b1, 1, 0, 2};
        vecs[7] = '{1'b0, 3, 1'b1, 0, 0, 2};
        vecs[8] = '{1'b1, 1, 1'b1, 0, 0, 3};
        vecs[9] = '{1'b0, 4, 1'b0, 0, 1, 3};

        for (int v = 0; v < 10; v++) begin
            press_seen   = 0;
            release_seen = 0;
            repeat (vecs[v].ticks) tick(vecs[v].raw, 1'b0);
            check("vec_clean", btn_clean, vecs[v].clean);
            check("vec_press_cnt", press_seen, vecs[v].press);
            check("vec_release_cnt", release_seen, vecs[v].rel);
            check("vec_bounce", bounce_count, vecs[v].bounce);
        end

        // Continuous sampling: press accepted on the 6th edge after btn_raw rises.
        btn_raw = 1'b0;
        do_reset();
        sample_en = 1'b1;
        btn_raw   = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            cycle();
            if (e < 6) check("cont_clean_low", btn_clean, 0);
            if (e == 6) begin
                check("cont_clean_high", btn_clean, 1);
                check("cont_press", press_pulse, 1);
            end
            if (e == 7) check("cont_press_end", press_pulse, 0);
        end
        sample_en = 1'b0;
        btn_raw   = 1'b0;
        do_reset();

        // Bounce saturation.
        press_seen = 0;
        for (int i = 0; i < 300; i++) begin
            tick(1'b1, 1'b0);
            tick(1'b1, 1'b0);
            tick(1'b0, 1'b0);
            if (i == 0) check("bounce_first", bounce_count, 1);
        end
        check("bounce_sat", bounce_count, BMAX);
        check("bounce_no_press", press_seen, 0);
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        check("bounce_sat_hold", bounce_count, BMAX);
        check("bounce_clean_low", btn_clean, 0);

        // Clear coincident with an aborted fall.
        repeat (4) tick(1'b1, 1'b0);
        check("clr_pre_clean", btn_clean, 1);
        release_seen = 0;
        repeat (2) tick(1'b0, 1'b0);
        tick(1'b1, 1'b1);
        check("clr_bounce", bounce_count, 0);
        check("clr_clean", btn_clean, 1);
        check("clr_no_release", release_seen, 0);
        release_seen = 0;
        repeat (4) tick(1'b0, 1'b0);
        check("rel_clean", btn_clean, 0);
        check("rel_pulses", release_seen, 1);

        // Reset while rising with three agreeing samples taken.
        tick(1'b1, 1'b0);
        tick(1'b0, 1'b0);
        repeat (3) tick(1'b1, 1'b0);
        check("mid_pre_clean", btn_clean, 0);
        press_seen = 0;
        do_reset();
        check("mid_bounce", bounce_count, 0);
        repeat (3) tick(1'b1, 1'b0);
        check("mid_after3_clean", btn_clean, 0);
        check("mid_after3_press", press_seen, 0);
        tick(1'b1, 1'b0);
        check("mid_after4_clean", btn_clean, 1);
        check("mid_after4_press", press_seen, 1);

        // Randomized segments of varying bounce rate and sampling density.
        btn_raw = 1'b0;
        do_reset();
        for (int seg = 0; seg < 30; seg++) begin
            int flip_rate;
            int en_rate;
            flip_rate = $urandom_range(40, 2);
            en_rate   = $urandom_range(4, 1);
            for (int c = 0; c < 100; c++) begin
                if ($urandom_range(flip_rate - 1, 0) == 0) btn_raw = ~btn_raw;
                sample_en  = ($urandom_range(en_rate - 1, 0) == 0);
                bounce_clr = ($urandom_range(63, 0) == 0);
                cycle();
            end
        end
        sample_en  = 1'b0;
        bounce_clr = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
